// File: rtl/binary_to_grey.sv
// Combinational binary to Gray-code encoder; inverse of grey_to_binary.
module binary_to_grey #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] grey
);

  assign grey = binary ^ (binary >> 1);

endmodule

// File: rtl/grey_to_binary.sv
// Combinational Gray-code to binary decoder; inverse of binary_to_grey.
module grey_to_binary #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] binary
);

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    binary = '0;
    for (int i = 0; i < WIDTH; i++) begin
      binary[i] = ^(grey >> i);
    end
  end

endmodule

// File: rtl/grey_counter.sv
// Up/down counter with registered binary and Gray-coded outputs plus a wrap pulse.
// The Gray register is fed from Gray(next_binary) so count_grey is a bare flop output.
module grey_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             direction,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] count_binary,
  output logic [WIDTH-1:0] count_grey,
  output logic             wrap
);

  localparam logic DIRECTION_UP   = 1'b0;
  localparam logic DIRECTION_DOWN = 1'b1;

  localparam logic [WIDTH-1:0] RESET_BIN  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_GREY = RESET_BIN ^ (RESET_BIN >> 1);

  logic [WIDTH-1:0] next_binary;
  logic [WIDTH-1:0] next_grey;
  logic             next_wrap;

  // Priority: clear > load > step > hold.
  always_comb begin
    next_binary = count_binary;
    next_wrap   = 1'b0;
    if (clear) begin
      next_binary = '0;
    end else if (load_enable) begin
      next_binary = load_value;
    end else if (enable) begin
      case (direction)
        DIRECTION_UP: begin
          next_binary = count_binary + 1'b1;
          next_wrap   = &count_binary;
        end
        DIRECTION_DOWN: begin
          next_binary = count_binary - 1'b1;
          next_wrap   = (count_binary == '0);
        end
      endcase
    end
  end

  binary_to_grey #(
    .WIDTH(WIDTH)
  ) u_encode (
    .binary(next_binary),
    .grey  (next_grey)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_binary <= RESET_BIN;
      count_grey   <= RESET_GREY;
      wrap         <= 1'b0;
    end else begin
      count_binary <= next_binary;
      count_grey   <= next_grey;
      wrap         <= next_wrap;
    end
  end

endmodule

// File: tb/tb_grey_counter.sv
// Directed and randomised checks of grey_counter with WIDTH=4, RESET_VALUE=5.
module tb_grey_counter;

  localparam int unsigned WIDTH = 4;

  logic             clock = 1'b0;
  logic             resetn;
  logic             enable;
  logic             direction;
  logic             load_enable;
  logic [WIDTH-1:0] load_value;
  logic             clear;
  logic [WIDTH-1:0] count_binary;
  logic [WIDTH-1:0] count_grey;
  logic             wrap;
  logic [WIDTH-1:0] decoded;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-written 4-bit Gray code table.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};

  grey_counter #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(5)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .direction   (direction),
    .load_enable (load_enable),
    .load_value  (load_value),
    .clear       (clear),
    .count_binary(count_binary),
    .count_grey  (count_grey),
    .wrap        (wrap)
  );

  grey_to_binary #(
    .WIDTH(WIDTH)
  ) u_dec (
    .grey  (count_grey),
    .binary(decoded)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] b, input logic [3:0] g,
                             input logic w);
    check({tag, "_bin"}, 32'(count_binary), 32'(b));
    check({tag, "_grey"}, 32'(count_grey), 32'(g));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  logic [3:0] prev_grey;
  logic [3:0] m_bin;
  logic       m_wrap;
  logic       only_step;

  initial begin
    resetn = 1'b0; enable = 1'b0; direction = 1'b0;
    load_enable = 1'b0; load_value = '0; clear = 1'b0;
    #12;
    check_state("reset", 4'd5, 4'b0111, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    step();
    check_state("post_release_hold", 4'd5, 4'b0111, 1'b0);

    // Asynchronous reset mid-count at 9.
    load_enable = 1'b1; load_value = 4'd9;
    step();
    load_enable = 1'b0;
    check_state("load9", 4'd9, 4'b1101, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_state("async_reset", 4'd5, 4'b0111, 1'b0);
    @(negedge clock);
    resetn = 1'b1;

    clear = 1'b1;
    step();
    clear = 1'b0;
    check_state("clear", 4'd0, 4'd0, 1'b0);

    // Up-count 17 cycles from 0.
    enable = 1'b1; direction = 1'b0;
    prev_grey = count_grey;
    for (int i = 1; i <= 17; i++) begin
      step();
      check_state($sformatf("up%0d", i), 4'(i % 16), gray_tab[i % 16], i == 16);
      check("up_onebit", 32'($countones(prev_grey ^ count_grey)), 32'd1);
      check("up_decode", 32'(decoded), 32'(count_binary));
      prev_grey = count_grey;
    end

    // Down-count from 1.
    direction = 1'b1;
    step(); check_state("down0", 4'd0, 4'b0000, 1'b0);
    step(); check_state("down15", 4'd15, 4'b1000, 1'b1);
    step(); check_state("down14", 4'd14, 4'b1001, 1'b0);

    // Priority at count 15: clear beats load and a wrapping step.
    direction = 1'b0;
    step(); check_state("to15", 4'd15, 4'b1000, 1'b0);
    clear = 1'b1; load_enable = 1'b1; load_value = 4'd12;
    step(); check_state("prio_clear", 4'd0, 4'd0, 1'b0);
    clear = 1'b0;
    step(); check_state("prio_load", 4'd12, 4'b1010, 1'b0);

    // Hold at 7; direction toggling must not matter.
    load_value = 4'd7;
    step(); check_state("load7", 4'd7, 4'b0100, 1'b0);
    load_enable = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      direction = i[0];
      step();
      check_state("hold", 4'd7, 4'b0100, 1'b0);
    end

    // Randomised mixed controls against a reference model.
    m_bin = 4'd7;
    prev_grey = count_grey;
    for (int i = 0; i < 10000; i++) begin
      clear       = ($urandom_range(15) == 0);
      load_enable = ($urandom_range(7) == 0);
      load_value  = 4'($urandom_range(15));
      enable      = ($urandom_range(3) != 0);
      direction   = 1'($urandom_range(1));
      only_step   = enable && !clear && !load_enable;
      m_wrap = 1'b0;
      if (clear) m_bin = 4'd0;
      else if (load_enable) m_bin = load_value;
      else if (enable) begin
        if (direction) begin
          m_wrap = (m_bin == 4'd0);
          m_bin  = m_bin - 4'd1;
        end else begin
          m_wrap = (m_bin == 4'd15);
          m_bin  = m_bin + 4'd1;
        end
      end
      step();
      check("rnd_bin", 32'(count_binary), 32'(m_bin));
      check("rnd_wrap", 32'(wrap), 32'(m_wrap));
      check("rnd_decode", 32'(decoded), 32'(count_binary));
      if (only_step) check("rnd_onebit", 32'($countones(prev_grey ^ count_grey)), 32'd1);
      prev_grey = count_grey;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/grey_counter.md
Name: grey_counter

Overview:
Registered up/down counter that keeps a binary count and publishes a flop-driven Gray-coded copy of it.
- Typical use: read/write pointer source for CDC FIFOs.
  - `count_grey` crosses domains through a synchronizer.
  - The receiving side decodes it back to binary with `grey_to_binary`.
- Grey output comes straight from a register, so consecutive values differ in exactly one bit with no combinational glitches.

Parameters:
- `WIDTH`, 4, counter width in bits; legal range ≥ 2.
- `RESET_VALUE`, 0, binary count loaded on reset; must be < 2^WIDTH.

Ports:
- `clock`  input  1  rising-edge clock
- `resetn`  input  1  asynchronous active-low reset
- `enable`  input  1  advance the count by one step this cycle
- `direction`  input  1  0 = increment, 1 = decrement
- `load_enable`  input  1  load `load_value` this cycle
- `load_value`  input  WIDTH  binary value to load
- `clear`  input  1  force the count to 0 this cycle
- `count_binary`  output  WIDTH  current count, binary, registered
- `count_grey`  output  WIDTH  current count, Gray code, registered
- `wrap`  output  1  one-cycle pulse: the last step crossed max→0 (up) or 0→max (down)

Behaviour:
- Reset (`resetn` low, async, mid-operation included):
  - `count_binary` = `RESET_VALUE`.
  - `count_grey` = `RESET_VALUE` ^ (`RESET_VALUE` >> 1).
  - `wrap` = 0.
  - Deassertion is sampled synchronously; first update is on the first rising edge after release.
- Next-state priority each rising edge: `clear` > `load_enable` > `enable` > hold.
  - clear: binary = 0, grey = 0, `wrap` = 0.
  - load: binary = `load_value`, grey = Gray(`load_value`), `wrap` = 0. `load_value` is unrestricted.
  - enable, up: binary = binary + 1 mod 2^WIDTH. `wrap` = 1 iff old binary = 2^WIDTH−1.
  - enable, down: binary = binary − 1 mod 2^WIDTH. `wrap` = 1 iff old binary = 0.
  - hold: outputs unchanged, `wrap` = 0.
- Latency: one cycle from input sample to outputs.
  - `count_binary` and `count_grey` always update on the same edge and always satisfy `count_grey` == Gray(`count_binary`).
- Grey register:
  - Written from Gray(next_binary), computed combinationally before the flop. `count_grey` is a pure flop output with no logic after the register.
  - During enable-only operation, successive `count_grey` values differ in exactly one bit, including across wrap in either direction.
  - clear and load may change several bits; users must not clear/load while the grey value is being sampled cross-domain.
- Simultaneous events:
  - clear with load and/or enable: clear wins, no wrap.
  - load with enable: load wins, no wrap.
  - `direction` is ignored unless enable is the active action.
- `wrap` is registered, asserted for exactly one cycle per wrapping step. With back-to-back wraps (`WIDTH` wrap every 2^WIDTH cycles), each is a separate pulse.
- No X propagation: all flops reset; the next-state logic is a full case on the priority chain.

Decomposition:
- No shared package needed; no typedefs. The `direction` encoding is documented as a local parameter pair (`DIRECTION_UP` = 0, `DIRECTION_DOWN` = 1) inside the module.
- One natural sub-module: `binary_to_grey` (parameter `WIDTH`; `binary` in, `grey` out; grey = binary ^ (binary >> 1)). It is the combinational inverse of `grey_to_binary` and lives alongside it in the grey encoding directory.
- The bench instantiates `grey_to_binary` on `count_grey` to cross-check `count_binary`.

Test Plan:
- Reset with `RESET_VALUE`=5, `WIDTH`=4: hold `resetn` low, then release → `count_binary`=5, `count_grey`=4'b0111, `wrap`=0; assert reset mid-count at value 9 → outputs return to 5/0111 immediately without a clock edge.
- Up-count with `enable`=1, `direction`=0, for 17 cycles from 0 → binary 0,1,…,15,0,1. The grey sequence has Hamming distance 1 per step, including 1000→0000. `wrap`=1 only in the cycle after 15→0.
- Down-count from 1 with `direction`=1 → binary 0, then 15 with `wrap` pulse, then 14. Grey 0001→0000→1000→1001.
- Priority: same cycle `clear`=1, `load_enable`=1 (`load_value`=12), `enable`=1 at count 15 → binary 0, grey 0, `wrap`=0. Next cycle `load_enable`=1 with `enable`=1 → binary 12, grey 1010, `wrap`=0.
- Hold: `enable`=0 for 5 cycles at count 7 → binary stays 7, grey stays 0100, `wrap` stays 0.
- Random 10k cycles of mixed controls vs. a reference model → every cycle `grey_to_binary(count_grey)` == `count_binary`, `wrap` matches the model, and the single-bit-change check holds on every enable-only step.
